// File: rtl/rr_replay_bus_unpack_if.sv
// Replay bus seen by the unpacker's consumers.
// Each channel gets its own valid/ready handshake and qualifier bits.
// All channels share one logb_data bus, with channel 0 in the LSBs.
interface rr_replay_bus_t #(
    parameter int CHANNEL_CNT = 4,
    parameter int FULL_WIDTH  = 512
);
    logic [CHANNEL_CNT-1:0] valid;
    logic [CHANNEL_CNT-1:0] ready;
    logic [CHANNEL_CNT-1:0] logb_valid;
    logic [CHANNEL_CNT-1:0] loge_valid;
    logic [FULL_WIDTH-1:0]  logb_data;

    // Producer side: drives the per-channel qualifiers and data, consumes ready.
    modport P (
        output valid,
        output logb_valid,
        output loge_valid,
        output logb_data,
        input  ready
    );

    // Consumer side.
    modport C (
        input  valid,
        input  logb_valid,
        input  loge_valid,
        input  logb_data,
        output ready
    );
endinterface

// File: rtl/rr_replay_bus_unpack.sv
// rr_replay_bus_unpack: takes one transaction word at a time and fans it out
// to a set of independent replay channels. Each eligible channel keeps its
// pending bit until its own handshake completes. The next word is accepted on
// the same edge as the last outstanding handshake, so back-to-back words see
// no idle bubble.
// Optional build macro RR_REPLAY_UNPACK_STATS_EN adds two wrap-around
// counters: accepted non-empty words, and DIST cycles with no handshake.
module rr_replay_bus_unpack #(
    parameter int LOGB_CHANNEL_CNT = 4,
    parameter int LOGE_CHANNEL_CNT = 4,
    parameter int FULL_WIDTH       = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
    input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
    input  logic [FULL_WIDTH-1:0]       in_logb_data,
    rr_replay_bus_t.P                   out
`ifdef RR_REPLAY_UNPACK_STATS_EN
    ,
    output logic [31:0]                 stat_txn_cnt,
    output logic [31:0]                 stat_stall_cnt
`endif
);

    localparam int CH = LOGB_CHANNEL_CNT;

    typedef enum logic {
        IDLE = 1'b0,
        DIST = 1'b1
    } state_e;

    // Elaboration-time consistency checks between this block and the attached bus.
    if (FULL_WIDTH != out.FULL_WIDTH) begin : g_width_check
        $error("rr_replay_bus_unpack: FULL_WIDTH does not match out.FULL_WIDTH");
    end
    if (CH != out.CHANNEL_CNT) begin : g_chan_check
        $error("rr_replay_bus_unpack: LOGB_CHANNEL_CNT does not match out.CHANNEL_CNT");
    end
    if (LOGE_CHANNEL_CNT > LOGB_CHANNEL_CNT) begin : g_loge_check
        $error("rr_replay_bus_unpack: LOGE_CHANNEL_CNT exceeds LOGB_CHANNEL_CNT");
    end

    logic [CH-1:0]         logeExt;
    logic [CH-1:0]         eligible;
    logic [CH-1:0]         handshake;
    logic [CH-1:0]         remaining;
    logic                  accept;
    state_e                state;

    logic [CH-1:0]         pendingMask_q, pendingMask_d;
    logic [CH-1:0]         heldLogb_q,    heldLogb_d;
    logic [CH-1:0]         heldLoge_q,    heldLoge_d;
    logic [FULL_WIDTH-1:0] heldData_q,    heldData_d;

    // Widen the loge bits to one bit per channel.
    // Channels without a loge bit read as 0.
    for (genvar g = 0; g < CH; g++) begin : g_loge_ext
        if (g < LOGE_CHANNEL_CNT) begin : g_has_loge
            assign logeExt[g] = in_loge_valid[g];
        end else begin : g_no_loge
            assign logeExt[g] = 1'b0;
        end
    end

    assign eligible = in_logb_valid | logeExt;

    // State is derived from the pending mask, not stored separately.
    // A new word is taken when nothing would still be pending after this edge.
    always_comb begin
        handshake     = pendingMask_q & out.ready;
        remaining     = pendingMask_q & ~handshake;
        state         = (pendingMask_q == '0) ? IDLE : DIST;
        in_ready      = 1'b0;
        pendingMask_d = remaining;
        heldLogb_d    = heldLogb_q;
        heldLoge_d    = heldLoge_q;
        heldData_d    = heldData_q;
        if (!rst) begin
            in_ready = (state == IDLE) || (remaining == '0);
        end
        accept = in_valid && in_ready;
        if (accept) begin
            pendingMask_d = eligible;
            heldLogb_d    = in_logb_valid;
            heldLoge_d    = logeExt;
            heldData_d    = in_logb_data;
        end
    end

    // Register the pending mask and the held word; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pendingMask_q <= '0;
            heldLogb_q    <= '0;
            heldLoge_q    <= '0;
            heldData_q    <= '0;
        end else begin
            pendingMask_q <= pendingMask_d;
            heldLogb_q    <= heldLogb_d;
            heldLoge_q    <= heldLoge_d;
            heldData_q    <= heldData_d;
        end
    end

    assign out.valid      = rst ? '0 : pendingMask_q;
    assign out.logb_valid = rst ? '0 : (pendingMask_q & heldLogb_q);
    assign out.loge_valid = rst ? '0 : (pendingMask_q & heldLoge_q);
    assign out.logb_data  = heldData_q;

`ifdef RR_REPLAY_UNPACK_STATS_EN
    logic [31:0] txnCnt_q;
    logic [31:0] stallCnt_q;

    // Count accepted non-empty words, and DIST cycles where no channel completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            txnCnt_q   <= '0;
            stallCnt_q <= '0;
        end else begin
            if (accept && (eligible != '0)) begin
                txnCnt_q <= txnCnt_q + 32'd1;
            end
            if ((state == DIST) && (handshake == '0)) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
        end
    end

    assign stat_txn_cnt   = txnCnt_q;
    assign stat_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_rr_replay_bus_unpack.sv
// Bench for rr_replay_bus_unpack: LOGB=4, LOGE=2, FULL_WIDTH=128.
// It applies a table of per-cycle vectors, then runs a hand-written sequence.
// The stat counters are checked only when RR_REPLAY_UNPACK_STATS_EN is defined.
module tb_rr_replay_bus_unpack;

   localparam int LOGB = 4;
   localparam int LOGE = 2;
   localparam int FW   = 128;

   typedef struct {
      logic           rst;
      logic           inValid;
      logic [3:0]     logb;
      logic [1:0]     loge;
      logic [FW-1:0]  data;
      logic [3:0]     ready;
      logic           expReady;
      logic [3:0]     expValid;
      logic [3:0]     expLogbV;
      logic [3:0]     expLogeV;
      logic           chkData;
      logic [FW-1:0]  expData;
   } vec_t;

   logic            clk;
   logic            rst;
   logic            inValid;
   logic            inReady;
   logic [LOGB-1:0] inLogbValid;
   logic [LOGE-1:0] inLogeValid;
   logic [FW-1:0]   inLogbData;
`ifdef RR_REPLAY_UNPACK_STATS_EN
   logic [31:0]     statTxnCnt;
   logic [31:0]     statStallCnt;
`endif

   int assertCount = 0;
   int failCount   = 0;
   vec_t vecs[$];

   rr_replay_bus_t #(.CHANNEL_CNT(LOGB), .FULL_WIDTH(FW)) bus ();

   rr_replay_bus_unpack #(
      .LOGB_CHANNEL_CNT(LOGB),
      .LOGE_CHANNEL_CNT(LOGE),
      .FULL_WIDTH(FW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(inValid),
      .in_ready(inReady),
      .in_logb_valid(inLogbValid),
      .in_loge_valid(inLogeValid),
      .in_logb_data(inLogbData),
      .out(bus)
`ifdef RR_REPLAY_UNPACK_STATS_EN
      ,
      .stat_txn_cnt(statTxnCnt),
      .stat_stall_cnt(statStallCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(logic r, logic v, logic [3:0] lb, logic [1:0] le,
                                  logic [FW-1:0] d, logic [3:0] rdy, logic eRdy,
                                  logic [3:0] eV, logic [3:0] eLb, logic [3:0] eLe,
                                  logic cD, logic [FW-1:0] eD);
      vec_t t;
      t.rst = r; t.inValid = v; t.logb = lb; t.loge = le; t.data = d; t.ready = rdy;
      t.expReady = eRdy; t.expValid = eV; t.expLogbV = eLb; t.expLogeV = eLe;
      t.chkData = cD; t.expData = eD;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, then sample the outputs 1 time unit later.
   task automatic applyStimulus(input vec_t v, input string tag);
      @(negedge clk);
      rst         = v.rst;
      inValid     = v.inValid;
      inLogbValid = v.logb;
      inLogeValid = v.loge;
      inLogbData  = v.data;
      bus.ready   = v.ready;
      #1;
      checkOutput({tag, " in_ready"},   FW'(inReady),        FW'(v.expReady));
      checkOutput({tag, " valid"},      FW'(bus.valid),      FW'(v.expValid));
      checkOutput({tag, " logb_valid"}, FW'(bus.logb_valid), FW'(v.expLogbV));
      checkOutput({tag, " loge_valid"}, FW'(bus.loge_valid), FW'(v.expLogeV));
      if (v.chkData) checkOutput({tag, " logb_data"}, bus.logb_data, v.expData);
   endtask

   initial begin
      logic [FW-1:0] dD, dE, dF, dG, dH, dJ, dK, dL, dM, dN;
      dD = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
      dE = 128'h11111111_22222222_33333333_44444444;
      dF = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
      dG = 128'h0000000A_0000000B_0000000C_0000000D;
      dH = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
      dJ = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;
      dK = 128'h76543210_FEDCBA98_76543210_FEDCBA98;
      dL = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
      dM = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
      dN = 128'h99999999_88888888_77777777_66666666;

      rst = 1'b1; inValid = 1'b0; inLogbValid = '0; inLogeValid = '0;
      inLogbData = '0; bus.ready = '0;

      //                     rst v   logb     loge   data  ready    rdy valid    logbV    logeV    chk expData
      // 0-1: reset holds in_ready low and the bus quiet
      vecs.push_back(mkVec(1, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(1, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      // 2-4: one word, all consumers ready
      vecs.push_back(mkVec(0, 1, 4'b1011, 2'b00, dD, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1111, 1, 4'b1011, 4'b1011, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      // 5-11: staggered handshakes ch0, ch3, then ch1; ready on non-pending channels is ignored
      vecs.push_back(mkVec(0, 1, 4'b1011, 2'b00, dD, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0001, 0, 4'b1011, 4'b1011, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b1010, 4'b1010, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1000, 0, 4'b1010, 4'b1010, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1101, 0, 4'b0010, 4'b0010, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0010, 1, 4'b0010, 4'b0010, 4'b0000, 1, dD));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      // 12-14: loge-only word
      vecs.push_back(mkVec(0, 1, 4'b0000, 2'b10, dE, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0010, 1, dE));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0010, 1, 4'b0010, 4'b0000, 4'b0010, 1, dE));
      // 15-16: empty word is accepted and dropped
      vecs.push_back(mkVec(0, 1, 4'b0000, 2'b00, dF, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      // 17-20: back-to-back words with no bubble
      vecs.push_back(mkVec(0, 1, 4'b0101, 2'b01, dG, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 1, 4'b1110, 2'b10, dH, 4'b1111, 1, 4'b0101, 4'b0101, 4'b0001, 1, dG));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1111, 1, 4'b1110, 4'b1110, 4'b0010, 1, dH));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      // 21-24: next word waits for the last handshake, then loads on that same edge
      vecs.push_back(mkVec(0, 1, 4'b0011, 2'b00, dJ, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 1, 4'b1000, 2'b00, dK, 4'b0001, 0, 4'b0011, 4'b0011, 4'b0000, 1, dJ));
      vecs.push_back(mkVec(0, 1, 4'b1000, 2'b00, dK, 4'b0010, 1, 4'b0010, 4'b0010, 4'b0000, 1, dJ));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 1, dK));
      // 25-29: reset while a word is pending discards it
      vecs.push_back(mkVec(0, 1, 4'b0110, 2'b10, dL, 4'b1000, 1, 4'b1000, 4'b1000, 4'b0000, 1, dK));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b0110, 4'b0110, 4'b0010, 1, dL));
      vecs.push_back(mkVec(1, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 1, '0));
      vecs.push_back(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], $sformatf("row%0d", i));
      end

`ifdef RR_REPLAY_UNPACK_STATS_EN
      checkOutput("stat_txn after reset",   FW'(statTxnCnt),   FW'(0));
      checkOutput("stat_stall after reset", FW'(statStallCnt), FW'(0));
`endif

      // Hand sequence: an empty word, then a full word held through five stall cycles.
      // A new word is then accepted on the same edge as the full word's handshake.
      applyStimulus(mkVec(0, 1, 4'b0000, 2'b00, dF, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0), "seq empty");
      applyStimulus(mkVec(0, 1, 4'b1111, 2'b11, dM, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0), "seq load");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 0, 4'b1111, 4'b1111, 4'b0011, 1, dM),
                       $sformatf("seq stall%0d", k));
      end
      applyStimulus(mkVec(0, 1, 4'b0001, 2'b00, dN, 4'b1111, 1, 4'b1111, 4'b1111, 4'b0011, 1, dM), "seq swap");
      applyStimulus(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b1111, 1, 4'b0001, 4'b0001, 4'b0000, 1, dN), "seq second");
      applyStimulus(mkVec(0, 0, 4'b0000, 2'b00, '0, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 0, '0), "seq idle");
`ifdef RR_REPLAY_UNPACK_STATS_EN
      checkOutput("stat_txn after seq",   FW'(statTxnCnt),   FW'(2));
      checkOutput("stat_stall after seq", FW'(statStallCnt), FW'(5));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rr_replay_bus_unpack.md
RR_REPLAY_BUS_UNPACK -- requirements
Module: rr_replay_bus_unpack

Interface
- REQ-001: Parameter LOGB_CHANNEL_CNT, default 4: number of replay channels on the out bus.
- REQ-002: Parameter LOGE_CHANNEL_CNT, default 4: number of channels carrying a loge bit (LOGE_CHANNEL_CNT <= LOGB_CHANNEL_CNT); channel i < LOGE_CHANNEL_CNT owns loge bit i.
- REQ-003: Parameter FULL_WIDTH, default 512: concatenated logb data width; SHALL equal out.FULL_WIDTH (elaboration $error otherwise).
- REQ-004: clk  input  1  sole clock; all state on rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: in_valid  input  1  transaction word valid.
- REQ-007: in_ready  output  1  unpacker accepts word this cycle.
- REQ-008: in_logb_valid  input  LOGB_CHANNEL_CNT  per-channel logb bit of the word.
- REQ-009: in_loge_valid  input  LOGE_CHANNEL_CNT  per-channel loge bit of the word.
- REQ-010: in_logb_data  input  FULL_WIDTH  concatenated channel data, channel 0 at LSB.
- REQ-011: out  rr_replay_bus_t.P  -  replay bus: valid, ready, logb_valid, loge_valid per channel; logb_data FULL_WIDTH.

Function
- REQ-012: Two states: IDLE (pending mask == 0) and DIST (pending mask != 0); state is derived from the pending mask.
- REQ-013: Channel i is pending-eligible if in_logb_valid[i] OR (i < LOGE_CHANNEL_CNT AND in_loge_valid[i]).
- REQ-014: in_ready = 1 in IDLE, or in DIST when every pending channel has out.ready high this cycle (back-to-back accept; combinational out.ready -> in_ready path allowed).
- REQ-015: On in_valid && in_ready: held logb/loge bits and data register the word; pending mask <= eligible mask; visible on out the next cycle (latency 1).
- REQ-016: A word with no eligible channel SHALL be accepted and dropped; state stays/returns IDLE.
- REQ-017: out.valid[i] = pending[i]; out.logb_valid[i] = pending[i] & held_logb[i]; out.loge_valid[i] = pending[i] & held_loge[i] (0 for i >= LOGE_CHANNEL_CNT).
- REQ-018: out.logb_data = held data, stable while any channel pending.
- REQ-019: out.valid[i] && out.ready[i] clears pending[i] at the clock edge; channels complete independently, in any order.
- REQ-020: pending[i] SHALL remain set until its handshake; out.ready for non-pending channels is ignored.
- REQ-021: Last-channel handshake with simultaneous in_valid loads the new word same edge; no IDLE bubble.
- REQ-022: No word is lost or duplicated; each eligible channel of each accepted word gets exactly one handshake.

Reset
- REQ-023: While rst is high: pending mask, held bits and held data <= 0; in_ready = 0; all out valid/logb_valid/loge_valid = 0.
- REQ-024: Reset mid-DIST discards the held word; first cycle after rst low is IDLE with in_ready = 1.

Configuration
- REQ-025: Macro RR_REPLAY_UNPACK_STATS_EN defined: adds outputs stat_txn_cnt (32, accepted non-empty words) and stat_stall_cnt (32, cycles in DIST with no channel handshake), both wrap at 2^32, reset to 0.
- REQ-026: Macro undefined: those ports and counters are absent; all other behaviour identical.

Verification (LOGB=4, LOGE=2, 32-bit channels, FULL_WIDTH=128)
- REQ-027: Word logb=4'b1011, loge=2'b00, data=128'hD3_C2_B1_A0 pattern, all out.ready=1 -> next cycle out.valid=4'b1011, data held; following cycle pending=0, in_ready=1.
- REQ-028: Same word, out.ready raised ch0 cycle1, ch3 cycle3, ch1 cycle5 -> out.valid 1011->1010->0010->0000; in_ready 0 until cycle5 ready, 1 then.
- REQ-029: Word logb=0, loge=2'b10 -> out.valid=4'b0010, out.loge_valid[1]=1, out.logb_valid=0.
- REQ-030: Empty word logb=0, loge=0 -> accepted, out.valid stays 0, stat_txn_cnt unchanged.
- REQ-031: Two back-to-back words, all ready=1 -> second presented the cycle after first's handshakes, zero bubbles; stat_txn_cnt=2.
- REQ-032: rst asserted one cycle with out.valid=4'b0110 -> out.valid=0, in_ready=1 after release, old word never reappears.
